// File: rtl/debounce_pkg.sv
// debounce_pkg: shared FSM encoding and joystick channel indices for debounce_array.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHK_HI = 2'd1,
        ST_HELD   = 2'd2,
        ST_CHK_LO = 2'd3
    } state_e;

    // Bit order matches the LED bus {up,down,left,right,fire}.
    localparam int CH_UP    = 4;
    localparam int CH_DOWN  = 3;
    localparam int CH_LEFT  = 2;
    localparam int CH_RIGHT = 1;
    localparam int CH_FIRE  = 0;

    function automatic logic is_high(state_e s);
        return s == ST_HELD || s == ST_CHK_LO;
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one channel's synchroniser, counter debounce FSM and press/release pulses.
// Hold-to-repeat press pulses are built only when DEBOUNCE_AUTOREPEAT_EN is defined.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int CNT_W      = 20,
    parameter int STABLE_CYC = 500000,
    parameter int RPT_W      = 26,
    parameter int REPEAT_DLY = 25000000,
    parameter int REPEAT_PER = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_level_nxt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
    localparam bit ONE_SHOT = (STABLE_CYC == 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             rpt_hit;

    if (STABLE_CYC < 1 || 64'(STABLE_CYC) >= (64'd1 << CNT_W) || REPEAT_DLY < 1 || REPEAT_PER < 1 ||
        64'(REPEAT_DLY) > (64'd1 << RPT_W) || 64'(REPEAT_PER) > (64'd1 << RPT_W)) begin : g_param_check
        $error("debounce_channel: counter parameters out of range");
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (sync2_q) begin
                state_d = ONE_SHOT ? ST_HELD : ST_CHK_HI;
                cnt_d   = ONE_SHOT ? '0 : CNT_W'(1);
            end
            ST_CHK_HI: begin
                state_d = !sync2_q ? ST_IDLE : (cnt_q == CNT_LAST) ? ST_HELD : ST_CHK_HI;
                cnt_d   = (!sync2_q || cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            end
            ST_HELD: if (!sync2_q) begin
                state_d = ONE_SHOT ? ST_IDLE : ST_CHK_LO;
                cnt_d   = ONE_SHOT ? '0 : CNT_W'(1);
            end
            ST_CHK_LO: begin
                state_d = sync2_q ? ST_HELD : (cnt_q == CNT_LAST) ? ST_IDLE : ST_CHK_LO;
                cnt_d   = (sync2_q || cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            end
            default: ;
        endcase
        level_d   = is_high(state_q);
        press_d   = (level_d && !level_q) || rpt_hit;
        release_d = !level_d && level_q;
    end

`ifdef DEBOUNCE_AUTOREPEAT_EN
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DLY - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PER - 1);

    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_per_q, rpt_per_d;
    logic             rpt_run;

    // Counting restarts on the first level-high cycle, so the first repeat lands REPEAT_DLY after the press pulse.
    always_comb begin
        rpt_run   = level_q && is_high(state_q);
        rpt_hit   = rpt_run && rpt_cnt_q == (rpt_per_q ? PER_LAST : DLY_LAST);
        rpt_cnt_d = (!rpt_run || rpt_hit) ? '0 : rpt_cnt_q + 1'b1;
        rpt_per_d = rpt_run && (rpt_per_q || rpt_hit);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rpt_cnt_q <= '0;
            rpt_per_q <= 1'b0;
        end else begin
            rpt_cnt_q <= rpt_cnt_d;
            rpt_per_q <= rpt_per_d;
        end
    end
`else
    assign rpt_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync1_q   <= i_raw;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign o_level     = level_q;
    assign o_press     = press_q;
    assign o_release   = release_q;
    assign o_level_nxt = level_d;

endmodule

// File: rtl/debounce_array.sv
// debounce_array: N-channel button/joystick conditioner producing debounced levels and press/release pulses.
// Defining DEBOUNCE_AUTOREPEAT_EN adds hold-to-repeat press pulses in every channel.
module debounce_array
    import debounce_pkg::*;
#(
    parameter int NUM_CH     = 5,
    parameter int CNT_W      = 20,
    parameter int STABLE_CYC = 500000,
    parameter int ACTIVE_LOW = 0,
    parameter int RPT_W      = 26,
    parameter int REPEAT_DLY = 25000000,
    parameter int REPEAT_PER = 5000000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] i_raw,
    output logic [NUM_CH-1:0] o_level,
    output logic [NUM_CH-1:0] o_press,
    output logic [NUM_CH-1:0] o_release,
    output logic              o_any
);

    logic [NUM_CH-1:0] raw_pol;
    logic [NUM_CH-1:0] level_nxt;
    logic              any_q, any_d;

    // Inverting ahead of the synchroniser is equivalent, since its flops reset to the not-pressed value.
    assign raw_pol = i_raw ^ {NUM_CH{ACTIVE_LOW != 0}};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        debounce_channel #(
            .CNT_W(CNT_W),
            .STABLE_CYC(STABLE_CYC),
            .RPT_W(RPT_W),
            .REPEAT_DLY(REPEAT_DLY),
            .REPEAT_PER(REPEAT_PER)
        ) u_ch (
            .clk(clk),
            .rst_n(rst_n),
            .i_raw(raw_pol[g]),
            .o_level(o_level[g]),
            .o_press(o_press[g]),
            .o_release(o_release[g]),
            .o_level_nxt(level_nxt[g])
        );
    end

    always_comb any_d = |level_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) any_q <= 1'b0;
        else any_q <= any_d;
    end

    assign o_any = any_q;

endmodule

// File: tb/tb_debounce_array.sv
// tb_debounce_array: drives an active-high and an active-low instance with the same logical stimulus
// and checks both against a run-length reference model of the debounce rules.
module tb_debounce_array;

    localparam int N  = 5;
    localparam int SC = 4;
    localparam int RD = 10;
    localparam int RP = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] raw = '0;
    logic [N-1:0] lv0, pr0, rl0, lv1, pr1, rl1;
    logic         an0, an1;
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    debounce_array #(.NUM_CH(N), .STABLE_CYC(SC), .ACTIVE_LOW(0), .REPEAT_DLY(RD), .REPEAT_PER(RP)) dut0 (
        .clk(clk), .rst_n(rst_n), .i_raw(raw),
        .o_level(lv0), .o_press(pr0), .o_release(rl0), .o_any(an0)
    );

    debounce_array #(.NUM_CH(N), .STABLE_CYC(SC), .ACTIVE_LOW(1), .REPEAT_DLY(RD), .REPEAT_PER(RP)) dut1 (
        .clk(clk), .rst_n(rst_n), .i_raw(~raw),
        .o_level(lv1), .o_press(pr1), .o_release(rl1), .o_any(an1)
    );

    // Reference: logical pressed level flips once SC consecutive synchronised samples disagree with it;
    // outputs follow one cycle later; repeats fall at k = RD, RD+RP, ... cycles into a held level.
    logic [N-1:0] m_s1, m_s2, m_st, m_level, m_press, m_release;
    int           m_run [N];
    int           m_k   [N];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_s1 <= '0; m_s2 <= '0; m_st <= '0;
            m_level <= '0; m_press <= '0; m_release <= '0;
            for (int c = 0; c < N; c++) begin
                m_run[c] <= 0;
                m_k[c]   <= 0;
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                automatic logic nl  = m_st[c];
                automatic int   k   = (nl && m_level[c]) ? m_k[c] + 1 : 0;
                automatic int   run = (m_s2[c] != m_st[c]) ? m_run[c] + 1 : 0;
                automatic logic rep = 1'b0;
`ifdef DEBOUNCE_AUTOREPEAT_EN
                rep = nl && (k == RD || (k > RD && (k - RD) % RP == 0));
`endif
                m_press[c]   <= (nl && !m_level[c]) || rep;
                m_release[c] <= !nl && m_level[c];
                m_level[c]   <= nl;
                m_k[c]       <= k;
                m_st[c]      <= (run == SC) ? !m_st[c] : m_st[c];
                m_run[c]     <= (run == SC) ? 0 : run;
            end
            m_s2 <= m_s1;
            m_s1 <= raw;
        end
    end

    logic [3*N:0] exp_v, obs0, obs1;
    assign exp_v = {m_level, m_press, m_release, |m_level};
    assign obs0  = {lv0, pr0, rl0, an0};
    assign obs1  = {lv1, pr1, rl1, an1};

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        raw   = '1;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({obs0, obs1} !== '0) begin
                n_bad++;
                $display("FAIL reset_zero: al0=%h al1=%h want 0", obs0, obs1);
            end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 18; i++) begin
            if (i == 10) raw = '0;
            tick();
            n_cmp++;
            if (obs0 !== exp_v || obs1 !== exp_v) begin
                n_bad++;
                $display("FAIL reset_model i=%0d: al0=%h al1=%h want %h", i, obs0, obs1, exp_v);
            end
            if (i == SC + 1) begin
                n_cmp++;
                if (lv0 !== '0 || lv1 !== '0) begin
                    n_bad++;
                    $display("FAIL reset_early: level %h/%h want 00", lv0, lv1);
                end
            end
            if (i == SC + 2) begin
                n_cmp++;
                if (lv0 !== 5'h1f || pr0 !== 5'h1f || lv1 !== 5'h1f || pr1 !== 5'h1f || !an0 || !an1) begin
                    n_bad++;
                    $display("FAIL reset_accept: level %h/%h press %h/%h want 1f/1f", lv0, lv1, pr0, pr1);
                end
            end
            if (i == SC + 3) begin
                n_cmp++;
                if (pr0 !== '0 || pr1 !== '0 || lv0 !== 5'h1f) begin
                    n_bad++;
                    $display("FAIL reset_pulse_len: press %h/%h want 00", pr0, pr1);
                end
            end
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 16; i++) begin
            raw[0] = (i < 3);
            tick();
            n_cmp++;
            if (obs0 !== exp_v || obs1 !== exp_v || {lv0[0], pr0[0], rl0[0], lv1[0], pr1[0], rl1[0]} !== '0) begin
                n_bad++;
                $display("FAIL glitch i=%0d: al0=%h al1=%h want %h with ch0 quiet", i, obs0, obs1, exp_v);
            end
        end
    endtask

    task automatic test_press_release();
        for (int i = 0; i < 34; i++) begin
            raw[2] = (i < 20);
            tick();
            n_cmp++;
            if (obs0 !== exp_v || obs1 !== exp_v) begin
                n_bad++;
                $display("FAIL press_model i=%0d: al0=%h al1=%h want %h", i, obs0, obs1, exp_v);
            end
            if (i == SC + 2 || i == SC + 22) begin
                n_cmp++;
                if ({lv0[2], pr0[2], rl0[2]} !== ((i == SC + 2) ? 3'b110 : 3'b001) ||
                    {lv1[2], pr1[2], rl1[2]} !== ((i == SC + 2) ? 3'b110 : 3'b001)) begin
                    n_bad++;
                    $display("FAIL press_edge i=%0d: lvl/prs/rel %b%b%b want %b", i, lv0[2], pr0[2], rl0[2],
                             (i == SC + 2) ? 3'b110 : 3'b001);
                end
            end
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 10; i++) begin
            raw[4] = 1'b1;
            tick();
        end
        n_cmp++;
        if (lv0[4] !== 1'b1 || lv1[4] !== 1'b1) begin
            n_bad++;
            $display("FAIL bounce_held: level %b/%b want 1", lv0[4], lv1[4]);
        end
        for (int i = 0; i < 16; i++) begin
            raw[4] = (i == 1);
            tick();
            n_cmp++;
            if (obs0 !== exp_v || obs1 !== exp_v || {lv0[4], rl0[4]} !== {i < 8, i == 8}) begin
                n_bad++;
                $display("FAIL bounce i=%0d: al0=%h al1=%h want %h, ch4 lvl/rel %b%b", i, obs0, obs1, exp_v,
                         i < 8, i == 8);
            end
        end
    endtask

    task automatic test_midreset();
        for (int i = 0; i < 26; i++) begin
            raw[1] = (i < 16);
            rst_n  = (i != 4);
            tick();
            n_cmp++;
            if (obs0 !== exp_v || obs1 !== exp_v || (i < 16 && (pr0[1] !== (i == 11) || pr1[1] !== (i == 11)))) begin
                n_bad++;
                $display("FAIL midreset i=%0d: al0=%h al1=%h want %h, ch1 press %b", i, obs0, obs1, exp_v, i == 11);
            end
        end
    endtask

    task automatic test_repeat();
        int cnt0 = 0;
        int cnt1 = 0;
        for (int i = 0; i < 42; i++) begin
            raw[3] = (i < 30);
            tick();
            if (i < 30) begin
                cnt0 += int'(pr0[3]);
                cnt1 += int'(pr1[3]);
            end
            n_cmp++;
            if (obs0 !== exp_v || obs1 !== exp_v || (i >= 36 && (pr0[3] || pr1[3]))) begin
                n_bad++;
                $display("FAIL repeat i=%0d: al0=%h al1=%h want %h", i, obs0, obs1, exp_v);
            end
        end
`ifdef DEBOUNCE_AUTOREPEAT_EN
        n_cmp++;
        if (cnt0 !== 6 || cnt1 !== 6) begin
            n_bad++;
            $display("FAIL repeat_count: %0d/%0d pulses want 6", cnt0, cnt1);
        end
`else
        n_cmp++;
        if (cnt0 !== 1 || cnt1 !== 1) begin
            n_bad++;
            $display("FAIL repeat_count: %0d/%0d pulses want 1", cnt0, cnt1);
        end
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(4, 0) == 0) raw[c] = ~raw[c];
            rst_n = ($urandom_range(199, 0) != 0);
            tick();
            n_cmp++;
            if (obs0 !== exp_v || obs1 !== exp_v) begin
                n_bad++;
                $display("FAIL random i=%0d: al0=%h al1=%h want %h", i, obs0, obs1, exp_v);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_glitch();
        test_press_release();
        test_bounce();
        test_midreset();
        test_repeat();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
